// File: rtl/ks_prefix_adder_pipe_pkg.sv
// Shared sizing helpers and operation encoding for the pipelined Kogge-Stone adder.
package ks_adder_pkg;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int ks_levels(input int width);
        return clog2(width);
    endfunction

    function automatic int ks_nstg(input int width, input int lps);
        return ceil_div(ks_levels(width), lps);
    endfunction

    // One operand-capture register plus one register per group of prefix levels.
    function automatic int ks_lat(input int width, input int lps);
        return ks_nstg(width, lps) + 1;
    endfunction

endpackage

// File: rtl/ks_prefix_adder_pipe_if.sv
// Operand/result valid-ready bus between operand issue, the adder pipe and writeback.
interface ks_prefix_adder_pipe_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/ks_prefix_adder_pipe_level.sv
// One Kogge-Stone prefix row: grey/black cells combining each bit with the bit SPAN below it.
module ks_prefix_level #(
    parameter int WIDTH = 24,
    parameter int SPAN  = 1
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p_nxt,
    output logic [WIDTH-1:0] g_nxt
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < SPAN) begin : g_buf
            assign p_nxt[i] = p[i];
            assign g_nxt[i] = g[i];
        end else begin : g_cell
            assign g_nxt[i] = g[i] | (p[i] & g[i-SPAN]);
            assign p_nxt[i] = p[i] & p[i-SPAN];
        end
    end
endmodule

// File: rtl/ks_prefix_adder_pipe.sv
// Pipelined Kogge-Stone add/sub with valid/ready flow control and collapsing bubbles.
// Define KS_ADD_SAT_EN to saturate the sum on signed overflow instead of wrapping.
module ks_prefix_adder_pipe
    import ks_adder_pkg::*;
#(
    parameter int WIDTH         = 24,
    parameter int LVL_PER_STAGE = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    ks_prefix_adder_pipe_if.slave bus
);
    localparam int LEVELS = ks_levels(WIDTH);
    localparam int NSTG   = ks_nstg(WIDTH, LVL_PER_STAGE);
    localparam int LAT    = ks_lat(WIDTH, LVL_PER_STAGE);
    localparam int LAST   = LAT - 1;

    logic [LAST:0]              vld_pipe;
    logic [LAST:0]              en;
    logic [NSTG-1:0][WIDTH-1:0] p_q, g_q, p0_q;
    logic [NSTG-1:0]            cin_q;
    logic [WIDTH-1:0]           sum_q;
    logic                       cout_q, ovf_q;

    op_e              op;
    logic [WIDTH-1:0] b_eff, p_in, g_in;
    logic             cin_eff;

    // cin is folded into g[0] so every G[i] below is the true carry out of bit i.
    always_comb begin
        op      = op_e'(bus.in_sub);
        b_eff   = bus.in_b ^ {WIDTH{op == OP_SUB}};
        cin_eff = (op == OP_SUB) | bus.in_cin;
        p_in    = bus.in_a ^ b_eff;
        g_in    = bus.in_a & b_eff;
        g_in[0] = g_in[0] | (p_in[0] & cin_eff);
    end

    // A slot may load when it is empty or everything downstream of it is moving.
    for (genvar k = 0; k <= LAST; k++) begin : g_en
        assign en[k] = !((&vld_pipe[LAST:k]) && !bus.out_ready);
    end

    logic [WIDTH-1:0] grp_p [NSTG];
    logic [WIDTH-1:0] grp_g [NSTG];

    for (genvar j = 0; j < NSTG; j++) begin : g_grp
        logic [WIDTH-1:0] cp [LVL_PER_STAGE+1];
        logic [WIDTH-1:0] cg [LVL_PER_STAGE+1];
        assign cp[0] = p_q[j];
        assign cg[0] = g_q[j];
        for (genvar l = 0; l < LVL_PER_STAGE; l++) begin : g_lvl
            localparam int LVL = j * LVL_PER_STAGE + l;
            if (LVL < LEVELS) begin : g_row
                ks_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << LVL)) u_row (
                    .p     (cp[l]),
                    .g     (cg[l]),
                    .p_nxt (cp[l+1]),
                    .g_nxt (cg[l+1])
                );
            end else begin : g_pass
                assign cp[l+1] = cp[l];
                assign cg[l+1] = cg[l];
            end
        end
        assign grp_p[j] = cp[LVL_PER_STAGE];
        assign grp_g[j] = cg[LVL_PER_STAGE];
    end

    logic [WIDTH-1:0] g_fin, sum_c;
    logic             cout_c, ovf_c;

    always_comb begin
        g_fin  = grp_g[NSTG-1];
        sum_c  = p0_q[NSTG-1] ^ {g_fin[WIDTH-2:0], cin_q[NSTG-1]};
        cout_c = g_fin[WIDTH-1];
        ovf_c  = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
`ifdef KS_ADD_SAT_EN
        // On overflow both operands share a sign, and that sign equals the carry out.
        if (ovf_c)
            sum_c = cout_c ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            p_q      <= '0;
            g_q      <= '0;
            p0_q     <= '0;
            cin_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (en[0]) vld_pipe[0] <= bus.in_valid;
            for (int k = 1; k <= LAST; k++)
                if (en[k]) vld_pipe[k] <= vld_pipe[k-1];

            // Payload only moves with a valid beat so idle slots keep their last value.
            if (en[0] && bus.in_valid) begin
                p_q[0]   <= p_in;
                g_q[0]   <= g_in;
                p0_q[0]  <= p_in;
                cin_q[0] <= cin_eff;
            end
            for (int j = 1; j < NSTG; j++) begin
                if (en[j] && vld_pipe[j-1]) begin
                    p_q[j]   <= grp_p[j-1];
                    g_q[j]   <= grp_g[j-1];
                    p0_q[j]  <= p0_q[j-1];
                    cin_q[j] <= cin_q[j-1];
                end
            end
            if (en[LAST] && vld_pipe[LAST-1]) begin
                sum_q  <= sum_c;
                cout_q <= cout_c;
                ovf_q  <= ovf_c;
            end
        end
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = vld_pipe[LAST];
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_ks_prefix_adder_pipe.sv
// Self-checking bench: directed corner cases, backpressure, mid-flight reset, random beats vs. arithmetic model.
module tb_ks_prefix_adder_pipe;
    localparam int W   = 24;
    localparam int LPS = 2;
    localparam int LAT = ($clog2(W) + LPS - 1) / LPS + 1;
`ifdef KS_ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ks_prefix_adder_pipe_if #(.WIDTH(W)) bus ();
    ks_prefix_adder_pipe #(.WIDTH(W), .LVL_PER_STAGE(LPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_asrt = 0, n_fail = 0;
    int   cyc = 0, inflight = 0, popped = 0, full_seen = 0, last_acc = 0;
    bit   strict_lat = 1'b0;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Plain two's-complement arithmetic; overflow judged from operand and result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub | cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
        if (SAT && e.ovf) e.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        e.acc  = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: ordering, payload, latency, hold-while-stalled and in_ready rule.
    initial begin
        exp_t         e;
        bit           prev_stall, in_fire, out_fire;
        logic [W-1:0] held_sum;
        logic         held_cout, held_ovf;
        prev_stall = 1'b0;
        held_sum   = '0;
        held_cout  = 1'b0;
        held_ovf   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                inflight   = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(bus.out_valid), 64'(1));
                    chk("hold_sum", 64'(bus.out_sum), 64'(held_sum));
                    chk("hold_flags", 64'({bus.out_cout, bus.out_ovf}), 64'({held_cout, held_ovf}));
                end
                chk("in_ready_rule", 64'(bus.in_ready), 64'(!(inflight == LAT && !bus.out_ready)));
                if (!bus.in_ready) full_seen++;
                in_fire  = bus.in_valid && bus.in_ready;
                out_fire = bus.out_valid && bus.out_ready;
                if (out_fire) begin
                    if (exp_q.size() == 0) begin
                        chk("stale_beat", 64'(bus.out_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_sum", 64'(bus.out_sum), 64'(e.sum));
                        chk("beat_cout", 64'(bus.out_cout), 64'(e.cout));
                        chk("beat_ovf", 64'(bus.out_ovf), 64'(e.ovf));
                        if (strict_lat) chk("beat_latency", 64'(cyc - e.acc), 64'(LAT));
                        else            chk("beat_latency_min", 64'(cyc - e.acc >= LAT), 64'(1));
                        popped++;
                    end
                end
                if (in_fire) begin
                    e     = model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub);
                    e.acc = cyc;
                    exp_q.push_back(e);
                end
                inflight   = inflight + int'(in_fire) - int'(out_fire);
                prev_stall = bus.out_valid && !bus.out_ready;
                held_sum   = bus.out_sum;
                held_cout  = bus.out_cout;
                held_ovf   = bus.out_ovf;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int t;
        t = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 64'(bus.in_ready), 64'(1));
        last_acc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic one_shot(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        int t;
        t              = 0;
        bus.out_ready  = 1'b1;
        strict_lat     = 1'b1;
        send(a, b, cin, sub);
        @(negedge clk);
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_lat"}, 64'(cyc - last_acc), 64'(LAT));
        chk({tag, "_sum"}, 64'(bus.out_sum), 64'(es));
        chk({tag, "_cout"}, 64'(bus.out_cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(bus.out_ovf), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start, t;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_sum", 64'(bus.out_sum), 64'(0));
        chk("rst_out_flags", 64'({bus.out_cout, bus.out_ovf}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

        one_shot("add_wrap", 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0);
        one_shot("sub_borrow", 24'h000000, 24'h000001, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        one_shot("sub_pos", 24'h000005, 24'h000003, 1'b1, 1'b1, 24'h000002, 1'b1, 1'b0);
        one_shot("add_cin", 24'h000001, 24'h000001, 1'b1, 1'b0, 24'h000003, 1'b0, 1'b0);
        one_shot("pos_ovf", 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, SAT ? 24'h7FFFFF : 24'h800000, 1'b0, 1'b1);
        one_shot("neg_ovf", 24'h800000, 24'h800000, 1'b0, 1'b0, SAT ? 24'h800000 : 24'h000000, 1'b1, 1'b1);
        one_shot("sub_ovf", 24'h800000, 24'h000001, 1'b0, 1'b1, SAT ? 24'h800000 : 24'h7FFFFF, 1'b1, 1'b1);

        // 16 back-to-back beats against an out_ready pattern of 1,0,0,1.
        strict_lat = 1'b0;
        start      = popped;
        full_seen  = 0;
        fork
            for (int i = 0; i < 16; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
            begin
                int c;
                c = 0;
                while (popped - start < 16 && c < 400) begin
                    bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk);
                    #1;
                    c++;
                end
            end
        join
        chk("b2b_count", 64'(popped - start), 64'(16));
        chk("b2b_backpressure", 64'(full_seen > 0), 64'(1));

        // Random beats, output always ready: every beat must take exactly LAT.
        bus.out_ready = 1'b1;
        strict_lat    = 1'b1;
        start         = popped;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
        end
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rand_free_count", 64'(popped - start), 64'(2000));
        @(posedge clk);
        #1;

        // Random beats with random downstream stalls.
        strict_lat = 1'b0;
        start      = popped;
        fork
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(4) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
            end
            begin
                int c;
                c = 0;
                while (popped - start < 2000 && c < 30000) begin
                    bus.out_ready = 1'($urandom);
                    @(posedge clk);
                    #1;
                    c++;
                end
            end
        join
        chk("rand_stall_count", 64'(popped - start), 64'(2000));

        // Three beats parked in the pipe, then an asynchronous mid-cycle reset.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op(), 1'b0, 1'b0);
        repeat (LAT) @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("async_rst_sum", 64'(bus.out_sum), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'(bus.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        one_shot("after_rst", 24'h123456, 24'h654321, 1'b0, 1'b0, 24'h777777, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
